// File: rtl/lsu_multi.sv
// Load/store unit: decodes DMEM, output peripheral registers and a synchronised switch port,
// with B/H/W sign/zero-extended loads, byte-lane stores and a registered 1-cycle response.
module lsu_multi #(
    parameter int          DMEM_WORDS  = 1024,
    parameter int          N_OUT       = 11,
    parameter logic [31:0] SW_ADDR     = 32'h1800,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni_i,
    input  logic                 req_valid_i,
    input  logic                 req_we_i,
    input  logic [2:0]           req_size_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          st_data_i,
    input  logic [31:0]          io_sw_i,
    output logic                 rsp_valid_o,
    output logic                 rsp_err_o,
    output logic [31:0]          ld_data_o,
    output logic [32*N_OUT-1:0]  io_out_o
);

    localparam int          AW         = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);
    localparam logic [27:0] OUT_BASE   = 28'h100;
    localparam logic [27:0] OUT_END    = 28'(256 + N_OUT);

    logic          hit_dmem;
    logic          hit_out;
    logic          hit_sw;
    logic          size_bad;
    logic          misaligned;
    logic          req_err;
    logic          wr_ok;
    logic [3:0]    be;
    logic [31:0]   wr_word;
    logic [AW-1:0] dmem_idx;
    logic [31:0]   dmem_rd_word;
    logic [31:0]   out_rd;
    logic [31:0]   other_rd_next;
    logic [32*N_OUT-1:0] out_flat;
    logic [31:0]   sync_reg [SYNC_STAGES];

    logic          rsp_valid_reg;
    logic          rsp_err_reg;
    logic          ld_reg;
    logic          src_dmem_reg;
    logic [2:0]    size_reg;
    logic [1:0]    off_reg;
    logic [31:0]   other_rd_reg;
    logic [31:0]   ld_word;
    logic [31:0]   ld_shift;
    logic [31:0]   ld_ext;

    // Address decode on the full address
    assign hit_dmem = addr_i < DMEM_BYTES;
    assign hit_out  = (addr_i[31:4] >= OUT_BASE) && (addr_i[31:4] < OUT_END) && (addr_i[3:2] == 2'b00);
    assign hit_sw   = addr_i[31:2] == SW_ADDR[31:2];
    assign dmem_idx = addr_i[AW+1:2];

    assign size_bad   = (req_size_i[1:0] == 2'b11) || (req_size_i == 3'b110);
    assign misaligned = ((req_size_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((req_size_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    assign req_err    = size_bad || misaligned || !(hit_dmem || hit_out || hit_sw) ||
                        (req_we_i && hit_sw);
    assign wr_ok      = req_valid_i && req_we_i && !req_err;

    // Lane enables and lane-replicated store data so each lane picks its own byte
    always_comb begin
        be      = 4'b0000;
        wr_word = st_data_i;
        case (req_size_i[1:0])
            2'b00: begin
                be      = 4'b0001 << addr_i[1:0];
                wr_word = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                be      = addr_i[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{st_data_i[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Data memory split into byte lanes so partial stores map onto plain RAM writes
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DMEM_WORDS];
        logic [7:0] rd_reg;

        always_ff @(posedge clk_i) begin
            if (wr_ok && hit_dmem && be[gi]) begin
                mem[dmem_idx] <= wr_word[8*gi +: 8];
            end
            rd_reg <= mem[dmem_idx];
        end

        assign dmem_rd_word[8*gi +: 8] = rd_reg;
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
        logic        out_we;
        logic [31:0] q_reg;

        assign out_we = wr_ok && hit_out && (addr_i[7:4] == 4'(gi));

        always_ff @(posedge clk_i or negedge rst_ni_i) begin
            if (!rst_ni_i) begin
                q_reg <= '0;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (out_we && be[b]) begin
                        q_reg[8*b +: 8] <= wr_word[8*b +: 8];
                    end
                end
            end
        end

        assign out_flat[32*gi +: 32] = q_reg;
    end

    assign io_out_o = out_flat;

    always_ff @(posedge clk_i or negedge rst_ni_i) begin
        if (!rst_ni_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= '0;
            end
        end else begin
            sync_reg[0] <= io_sw_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
        end
    end

    always_comb begin
        out_rd = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (addr_i[7:4] == 4'(k)) begin
                out_rd = out_flat[32*k +: 32];
            end
        end
        other_rd_next = hit_sw ? sync_reg[SYNC_STAGES-1] : out_rd;
    end

    always_ff @(posedge clk_i or negedge rst_ni_i) begin
        if (!rst_ni_i) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            ld_reg        <= 1'b0;
            src_dmem_reg  <= 1'b0;
            size_reg      <= 3'b000;
            off_reg       <= 2'b00;
            other_rd_reg  <= '0;
        end else begin
            rsp_valid_reg <= req_valid_i;
            rsp_err_reg   <= req_valid_i && req_err;
            ld_reg        <= req_valid_i && !req_we_i && !req_err;
            src_dmem_reg  <= hit_dmem;
            size_reg      <= req_size_i;
            off_reg       <= addr_i[1:0];
            other_rd_reg  <= other_rd_next;
        end
    end

    // Extension happens after the RAM output register; gating by ld_reg keeps data 0 otherwise
    assign ld_word  = src_dmem_reg ? dmem_rd_word : other_rd_reg;
    assign ld_shift = ld_word >> {off_reg, 3'b000};

    always_comb begin
        case (size_reg)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_err_o   = rsp_err_reg;
    assign ld_data_o   = ld_reg ? ld_ext : 32'h0;

endmodule

// File: doc/lsu_multi.md
# lsu_multi

Parametrised load/store unit for the single-cycle/pipelined RV32 core. It decodes a data address into three regions: data memory, N_OUT write/read-back output peripheral registers, and one synchronised switch input port. It adds byte/halfword/word access with sign/zero extension, byte-lane stores and a registered 1-cycle load response. It also flags misaligned and unmapped accesses. All peripheral outputs come directly from reset-initialised registers.

## Interface
Parameters:
- DMEM_WORDS, 1024, data memory depth in 32-bit words (power of 2, ≤1024, so the region stays below 0x1000)
- N_OUT, 11, number of output peripheral registers (1..16); index k sits at 0x1000 + 16*k
- SW_ADDR, 32'h1800, address of the switch input register
- SYNC_STAGES, 2, synchroniser depth for io_sw_i (≥2)

Ports:
- clk_i  in  1  clock; everything is on its rising edge
- rst_ni_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  access request this cycle
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; store uses [1:0] only
- addr_i  in  32  byte address
- st_data_i  in  32  store data, right-aligned
- io_sw_i  in  32  asynchronous switch inputs
- rsp_valid_o  out  1  response for the request accepted the previous cycle
- rsp_err_o  out  1  that request was misaligned, unmapped or used an illegal size
- ld_data_o  out  32  extended load data; 0 for stores and errors
- io_out_o  out  32*N_OUT  packed output registers; slice k = register k (LEDR, LEDG, LCD, HEX map onto slices at top level)

## Operation
- Decode uses the full addr_i:
  - DMEM: addr < 4*DMEM_WORDS; word index = addr[log2(DMEM_WORDS)+1:2]
  - OUT k: addr[31:4] == (0x1000>>4)+k with k < N_OUT; byte offset = addr[1:0]; addr[3:2] must be 0, otherwise unmapped
  - SW: addr[31:2] == SW_ADDR[31:2]; read-only
  - Everything else is unmapped.
- Alignment: H/HU requires addr[0]=0; W requires addr[1:0]=0. Sizes 011, 110 and 111 are illegal.
- Error cases (misaligned, unmapped, illegal size, store to SW): no state changes, rsp_err_o=1, ld_data_o=0.
- Store: byte enables are derived from size and addr[1:0]. B writes lane addr[1:0] with st_data_i[7:0]. H writes lanes {addr[1],0}/{addr[1],1} with st_data_i[15:0]. W writes all lanes. Unselected lanes keep their value, in both DMEM and OUT registers.
- Load: select the word, shift right by 8*addr[1:0], then extend:
  - B: sign-extend bit 7
  - BU: zero-extend byte
  - H: sign-extend bit 15
  - HU: zero-extend half
  - W: raw word
- SW loads return the synchronised value (last stage of the synchroniser).
- io_out_o slice k always equals OUT register k. It is never gated by st_en or the request type.
- DMEM has no reset (contents are X until written). OUT registers and synchroniser stages reset to 0.

## Timing
- There is no backpressure: a request is accepted on every cycle where req_valid_i=1.
- Stores: DMEM/OUT update at the accepting edge. io_out_o reflects the new value in the cycle after the request.
- Responses: rsp_valid_o, rsp_err_o and ld_data_o are registered and valid in cycle N+1 for a request in cycle N. They are asserted for exactly one cycle. When rsp_valid_o=0, rsp_err_o and ld_data_o are 0.
- Back-to-back requests give back-to-back responses.
- Read-after-write to the same address in consecutive cycles: the load in N+1 returns the data stored in N; no forwarding hazard.
- io_sw_i reaches SW loads SYNC_STAGES cycles after it changes; plus 1 cycle for the response.
- Reset values: rsp_valid_o=0, rsp_err_o=0, ld_data_o=0, io_out_o=0. Reset asserted mid-operation clears any in-flight response immediately (asynchronously). An in-flight store at the reset edge is discarded for OUT registers; DMEM is not guaranteed.

## Test plan
- Reset: rst_ni_i low mid-burst -> rsp_valid_o, ld_data_o and io_out_o are 0 immediately. After release, a load from 0x1000 returns 0.
- Byte/half store and extended load:
  - SW 0x0000_0000 to 0x100, then SB 0xAB to 0x102 -> LW 0x100 returns 0x00AB_0000
  - LB 0x102 returns 0xFFFF_FFAB
  - LBU 0x102 returns 0x0000_00AB
  - SH 0x8001 to 0x100 -> LH 0x100 returns 0xFFFF_8001; LHU returns 0x0000_8001
- Output peripherals: SW 0x1234_5678 to 0x1000+16*(N_OUT-1) -> that io_out_o slice equals 0x1234_5678 in the next cycle and the other slices are unchanged. SB 0xFF to 0x1001 -> slice 0 = 0x0000_FF00.
- Switches: io_sw_i=0xDEAD_BEEF at cycle 0, then LW 0x1800 issued every cycle -> responses before cycle SYNC_STAGES+1 show the old value; from then on 0xDEAD_BEEF. SW to 0x1800 -> rsp_err_o=1 and no state change.
- Errors:
  - LW 0x102 -> err=1, data=0
  - LH 0x101 -> err=1, data=0
  - SW to 0x1004 or 0x2000 -> err=1, no register or memory change
  - size 011 -> err=1
- Throughput/RAW: SW 0x55 to 0x40 in cycle N and LW 0x40 in cycle N+1 -> response in N+2 = 0x55. Ten back-to-back loads give ten consecutive rsp_valid_o pulses.
